// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-requester RAM arbiter: requester indices and
// access-type encodings.
package mem_arbiter_pkg;

    localparam logic REQ0     = 1'b0;
    localparam logic REQ1     = 1'b1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // After a grant the other requester becomes the favoured one.
    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/ram_1rw.sv
// Single-port synchronous RAM with a registered read; maps onto one block-RAM port.
module ram_1rw #(
    parameter int addr_width = 6,
    parameter int data_width = 6
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [1 << addr_width];

    // NOTE: the array has no reset branch; clearing it would prevent block-RAM
    // inference, and the arbiter never exposes unread contents as valid data.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting two requesters share one single-port RAM; read data
// comes back one cycle after grant on the requester's own rvalid/rdata pair.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int addr_width = 6,
    parameter int data_width = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [addr_width-1:0] addr0,
    input  logic [data_width-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [data_width-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [addr_width-1:0] addr1,
    input  logic [data_width-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [data_width-1:0] rdata1
);

    logic                  pri_q, pri_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [data_width-1:0] hold0_q, hold0_d;
    logic [data_width-1:0] hold1_q, hold1_d;

    logic                  ram_en;
    logic                  ram_we;
    logic [addr_width-1:0] ram_addr;
    logic [data_width-1:0] ram_wdata;
    logic [data_width-1:0] ram_rdata;

    // NOTE: every output gets a default before the branches, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && (!req1 || pri_q == REQ0)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Grants are one-hot, so the winner's request simply steers the RAM port.
    always_comb begin
        ram_en    = gnt0 | gnt1;
        ram_we    = (gnt1 ? we1 : we0) == OP_WRITE;
        ram_addr  = gnt1 ? addr1 : addr0;
        ram_wdata = gnt1 ? wdata1 : wdata0;
    end

    always_comb begin
        pri_d = pri_q;
        if (gnt0) begin
            pri_d = other_req(REQ0);
        end else if (gnt1) begin
            pri_d = other_req(REQ1);
        end
        rvalid0_d = gnt0 && (we0 == OP_READ);
        rvalid1_d = gnt1 && (we1 == OP_READ);
        hold0_d   = rvalid0_q ? ram_rdata : hold0_q;
        hold1_d   = rvalid1_q ? ram_rdata : hold1_q;
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q     <= REQ0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            hold0_q   <= '0;
            hold1_q   <= '0;
        end else begin
            pri_q     <= pri_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            hold0_q   <= hold0_d;
            hold1_q   <= hold1_d;
        end
    end

    // The RAM's read register is shared; each port keeps its own copy of its last result.
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rvalid0_q ? ram_rdata : hold0_q;
    assign rdata1  = rvalid1_q ? ram_rdata : hold1_q;

    ram_1rw #(
        .addr_width(addr_width),
        .data_width(data_width)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference model predicts grants each cycle
// and queues the expected read-port state for the following cycle.
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;

    mem_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .we0    (we0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .gnt0   (gnt0),
        .rvalid0(rvalid0),
        .rdata0 (rdata0),
        .req1   (req1),
        .we1    (we1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .gnt1   (gnt1),
        .rvalid1(rvalid1),
        .rdata1 (rdata1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rv0;
        logic [DW-1:0] rd0;
        logic          rv1;
        logic [DW-1:0] rd1;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_mem [1 << AW];
    logic          m_pri;
    logic [DW-1:0] m_rd0, m_rd1;
    logic          mg0, mg1;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after posedge, check at negedge, advance model.
    task automatic cycle(input logic r,
                         input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        exp_t e;
        exp_t n;
        rst  = r;
        req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;
        #4;
        mg0 = !r && q0 && (!q1 || m_pri == 1'b0);
        mg1 = !r && q1 && !mg0;
        check("gnt0", {7'd0, gnt0}, {7'd0, mg0});
        check("gnt1", {7'd0, gnt1}, {7'd0, mg1});
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rvalid0", {7'd0, rvalid0}, {7'd0, e.rv0});
            check("rdata0",  {2'd0, rdata0},  {2'd0, e.rd0});
            check("rvalid1", {7'd0, rvalid1}, {7'd0, e.rv1});
            check("rdata1",  {2'd0, rdata1},  {2'd0, e.rd1});
        end
        if (r) begin
            m_pri = 1'b0;
            m_rd0 = '0;
            m_rd1 = '0;
            n = '0;
        end else begin
            n.rv0 = mg0 && !w0;
            n.rv1 = mg1 && !w1;
            if (n.rv0) m_rd0 = m_mem[a0];
            if (n.rv1) m_rd1 = m_mem[a1];
            if (mg0 && w0) m_mem[a0] = d0;
            if (mg1 && w1) m_mem[a1] = d1;
            if (mg0) m_pri = 1'b1;
            else if (mg1) m_pri = 1'b0;
            n.rd0 = m_rd0;
            n.rd1 = m_rd1;
        end
        exp_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic          p0, p1, pw0, pw1;
        logic [AW-1:0] pa0, pa1;
        logic [DW-1:0] pd0, pd1;

        m_pri = 1'b0;
        m_rd0 = '0;
        m_rd1 = '0;
        p0 = 1'b0;
        p1 = 1'b0;
        pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        @(posedge clk);
        #1;

        // Reset then idle.
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        idle();
        idle();

        // Fill the whole RAM so every later read has a known value.
        for (int i = 0; i < (1 << AW); i++) begin
            cycle(1'b0, 1'b1, 1'b1, AW'(i), DW'(i) ^ 6'h15, 1'b0, 1'b0, '0, '0);
        end

        // Single write then read on port 0.
        cycle(1'b0, 1'b1, 1'b1, 6'd5, 6'h2A, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 1'b0, 6'd5, '0,    1'b0, 1'b0, '0, '0);
        idle();

        // Contention from reset: alternating grants and read pulses.
        cycle(1'b0, 1'b1, 1'b1, 6'd1, 6'h11, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0,   '0,    1'b1, 1'b1, 6'd2, 6'h22);
        cycle(1'b1, 1'b0, 1'b0, '0,   '0,    1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b0, 6'd2, '0);
        end
        idle();

        // Cross-port read-after-write at the top address.
        cycle(1'b0, 1'b0, 1'b0, '0,    '0, 1'b1, 1'b1, 6'd63, 6'h3F);
        cycle(1'b0, 1'b1, 1'b0, 6'd63, '0, 1'b0, 1'b0, '0,    '0);
        idle();

        // Port 1 alone, then contention: port 0 must win first.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd2, '0);
        end
        cycle(1'b0, 1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b0, 6'd2, '0);
        cycle(1'b0, 1'b0, 1'b0, '0,   '0, 1'b1, 1'b0, 6'd2, '0);
        idle();

        // Reset arriving right behind a granted read; memory survives reset.
        cycle(1'b0, 1'b1, 1'b0, 6'd5, '0, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b1, 6'd5, 6'h00);
        idle();
        cycle(1'b0, 1'b1, 1'b0, 6'd5, '0, 1'b0, 1'b0, '0, '0);
        idle();

        // Random traffic; each requester holds its request until granted.
        for (int i = 0; i < 200; i++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; pw0 = 1'($urandom_range(0, 1));
                pa0 = AW'($urandom); pd0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1'b1; pw1 = 1'($urandom_range(0, 1));
                pa1 = AW'($urandom); pd1 = DW'($urandom);
            end
            cycle(1'b0, p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
            if (mg0) p0 = 1'b0;
            if (mg1) p1 = 1'b0;
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter in front of one inferred synchronous RAM.
- Each requester issues read or write accesses over a req/gnt handshake.
- At most one access reaches the RAM per clock. Read data returns one cycle after grant, tagged per requester.
- Used wherever two engines share a single RAM that maps to one block-RAM port.

Parameters:
- addr_width, 6, RAM address width; depth = 1<<addr_width words
- data_width, 6, RAM word width

Ports:
- clk  in  1  single system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 access request
- we0  in  1  requester 0: 1 = write, 0 = read; sampled with req0
- addr0  in  addr_width  requester 0 address
- wdata0  in  data_width  requester 0 write data
- gnt0  out  1  requester 0 access accepted this cycle (combinational)
- rvalid0  out  1  rdata0 holds requester 0 read result (registered)
- rdata0  out  data_width  requester 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for requester 1

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - pri_ptr <= 0 (requester 0 favoured).
  - rvalid0/rvalid1 <= 0; rdata0/rdata1 <= 0.
  - RAM contents not cleared.
  - gnt0/gnt1 forced 0 while rst=1.
- Arbitration (combinational, same cycle as req):
  - Only req0 asserted -> gnt0. Only req1 asserted -> gnt1.
  - Both asserted -> grant goes to pri_ptr.
  - gnt0 and gnt1 are never both 1.
- Priority update, at posedge when any grant is issued: pri_ptr <= index of the non-granted requester. No grant -> pri_ptr holds.
- Fairness: under continuous contention, grants alternate 0,1,0,1...; wait is bounded to 1 cycle.
- Handshake:
  - Requester holds req/we/addr/wdata stable until the cycle where gnt=1. The transfer completes at that posedge.
  - Requester may drop req or change the request the cycle after gnt.
  - Dropping req before grant is legal; nothing is performed.
- Write: granted write with we=1 -> mem[addr] <= wdata at that posedge. No rvalid produced.
- Read:
  - Granted read with we=0 -> at that posedge the granted port's rdata <= mem[addr] and rvalid <= 1.
  - Latency 1 cycle from grant to rvalid.
- rvalid is a single-cycle pulse per granted read. Back-to-back granted reads give consecutive pulses.
- rdata holds its last value when rvalid=0. The other port's rdata/rvalid are unaffected (its rvalid goes 0).
- Read-after-write:
  - Write granted in cycle N; read of the same address granted in cycle N+1 or later returns the new data.
  - No same-cycle collision is possible (one access per cycle).
- Read during write (same edge): impossible by construction; no bypass logic.
- Reset mid-operation:
  - A read granted in the same cycle rst=1 is dropped (gnt forced 0).
  - rvalid due in the cycle after rst is 0.
  - Memory writes are not performed while rst=1.
- Address wrap: addresses are full-width; there is no out-of-range case.

Decomposition:
- Package mem_arbiter_pkg:
  - REQ0=0 / REQ1=1 index constants
  - access-type constants OP_READ=0, OP_WRITE=1
- Sub-module ram_1rw: single-port synchronous RAM.
  - Ports: clk, en, we, addr, wdata, rdata.
  - Read registered, write-first irrelevant.
  - Parameterised by addr_width/data_width.
- mem_arbiter holds the arbiter, the muxes, the pri_ptr flop and the rvalid/rdata steering flops.

Test Plan:
- Reset then idle: rst=1 two cycles, then reqs=0 -> gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0.
- Single write/read: port0 writes addr=5 data=0x2A (gnt0 same cycle); next cycle port0 reads addr=5 -> gnt0, then next cycle rvalid0=1, rdata0=0x2A, rvalid1=0.
- Contention:
  - Both ports request reads continuously from reset (addr0=1, addr1=2, preloaded 0x11/0x22).
  - Grants alternate gnt0,gnt1,gnt0... starting with port 0.
  - rvalid0/rvalid1 pulses alternate one cycle later with 0x11/0x22.
- Cross-port RAW: port1 writes addr=63 data=0x3F in cycle N; port0 reads addr=63 in cycle N+1 -> rvalid0=1, rdata0=0x3F in cycle N+2.
- Priority hold: only req1 asserted for 3 cycles (gnt1 each cycle), then both request -> gnt0 first (pri_ptr=0 after each port-1 grant).
- Reset mid-read: port0 read granted in cycle N, rst=1 in cycle N+1 -> rvalid0=1 in N+1 (pre-reset grant). A read requested during rst gets no gnt and no rvalid. Previously written data is still readable after reset.
